// File: rtl/data_mem_responder.sv
// Data-memory responder for a pipeline MEM stage. A request is accepted, held for WAIT_CYCLES wait states, and then answered.
// Optional macro DMEM_RANGE_CHECK_EN flags out-of-range or misaligned accesses through resp_err.
module data_mem_responder #(
   parameter int DEPTH_WORDS = 64,
   parameter int WAIT_CYCLES = 2,
   parameter int BASE_ADDR   = 1024
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic        req_we,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   input  logic        resp_ready,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        busy
);

   localparam int          IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
   localparam logic [31:0] BASE     = 32'(BASE_ADDR);
   localparam logic [3:0]  CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t      r_state, w_next_state;
   logic [3:0]  r_cnt, w_next_cnt;
   logic        r_we;
   logic [31:0] r_addr, r_wdata;
   logic [31:0] r_rdata;
   logic        r_err;
   logic [31:0] r_mem [DEPTH_WORDS];

   logic             w_access, w_do_access, w_accept;
   logic             w_op_we, w_err;
   logic [31:0]      w_op_addr, w_op_wdata;
   logic [IDX_W-1:0] w_index;

   assign w_accept = (r_state == S_IDLE) && req_valid;

   // With zero wait states the access happens on the accepting edge, so the operands come straight from the inputs.
   assign w_op_we    = (r_state == S_IDLE) ? req_we    : r_we;
   assign w_op_addr  = (r_state == S_IDLE) ? req_addr  : r_addr;
   assign w_op_wdata = (r_state == S_IDLE) ? req_wdata : r_wdata;
   assign w_index    = IDX_W'(((w_op_addr - BASE) >> 2) % 32'(DEPTH_WORDS));

`ifdef DMEM_RANGE_CHECK_EN
   localparam logic [31:0] LIMIT = 32'(BASE_ADDR + 4 * DEPTH_WORDS);
   assign w_err = (w_op_addr < BASE) || (w_op_addr >= LIMIT) || (w_op_addr[1:0] != 2'b00);
`else
   assign w_err = 1'b0;
`endif

   // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
   always_comb begin
      w_next_state = r_state;
      w_next_cnt   = r_cnt;
      w_access     = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (req_valid) begin
               if (WAIT_CYCLES == 0) begin
                  w_next_state = S_RESP;
                  w_access     = 1'b1;
               end else begin
                  w_next_state = S_WAIT;
                  w_next_cnt   = CNT_INIT;
               end
            end
         end
         S_WAIT: begin
            if (r_cnt == 4'd0) begin
               w_next_state = S_RESP;
               w_access     = 1'b1;
            end else begin
               w_next_cnt = r_cnt - 4'd1;
            end
         end
         S_RESP: begin
            if (resp_ready) w_next_state = S_IDLE;
         end
         default: w_next_state = S_IDLE;
      endcase
   end

   // An access is never committed while reset is held, so a pending store cannot reach memory.
   assign w_do_access = w_access && !rst;

   // NOTE: sequential state uses non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= 4'd0;
         r_we    <= 1'b0;
         r_addr  <= 32'd0;
         r_wdata <= 32'd0;
         r_rdata <= 32'd0;
         r_err   <= 1'b0;
      end else begin
         r_state <= w_next_state;
         r_cnt   <= w_next_cnt;
         if (w_accept) begin
            r_we    <= req_we;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
         end
         if (w_do_access) begin
            r_rdata <= (w_err || w_op_we) ? 32'd0 : r_mem[w_index];
            r_err   <= w_err;
         end
      end
   end

   // NOTE: the memory array has no reset; its contents survive rst and it maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (w_do_access && w_op_we && !w_err) r_mem[w_index] <= w_op_wdata;
   end

   assign req_ready  = (r_state == S_IDLE) && !rst;
   assign resp_valid = (r_state == S_RESP);
   assign busy       = (r_state != S_IDLE);
   assign resp_rdata = r_rdata;
   assign resp_err   = r_err;

endmodule

// File: tb/tb_data_mem_responder.sv
// Randomized bench for data_mem_responder with a word-array reference model; a second instance covers zero wait states.
// Build with +define+DMEM_RANGE_CHECK_EN to exercise the range-check variant.
module tb_data_mem_responder;

   localparam int          DEPTH = 64;
   localparam int          WAITC = 2;
   localparam logic [31:0] BASE  = 32'd1024;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        req_valid = 1'b0, req_we = 1'b0, resp_ready = 1'b0;
   logic [31:0] req_addr = '0, req_wdata = '0;
   logic        req_ready, resp_valid, resp_err, busy;
   logic [31:0] resp_rdata;

   logic        z_req_valid = 1'b0, z_req_we = 1'b0, z_resp_ready = 1'b0;
   logic [31:0] z_req_addr = '0, z_req_wdata = '0;
   logic        z_req_ready, z_resp_valid, z_resp_err, z_busy;
   logic [31:0] z_resp_rdata;

   int          vectors = 0;
   int          miscompares = 0;
   logic [31:0] model_mem [DEPTH];

   always #5 clk = ~clk;

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITC), .BASE_ADDR(1024)) dut (
      .clk(clk), .rst(rst), .req_valid(req_valid), .req_we(req_we), .req_addr(req_addr),
      .req_wdata(req_wdata), .req_ready(req_ready), .resp_valid(resp_valid), .resp_ready(resp_ready),
      .resp_rdata(resp_rdata), .resp_err(resp_err), .busy(busy));

   data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(1024)) dut0 (
      .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_we(z_req_we), .req_addr(z_req_addr),
      .req_wdata(z_req_wdata), .req_ready(z_req_ready), .resp_valid(z_resp_valid), .resp_ready(z_resp_ready),
      .resp_rdata(z_resp_rdata), .resp_err(z_resp_err), .busy(z_busy));

   // Reference behaviour: what a single access returns, updating the model memory for legal stores.
   function automatic void model_access(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                                        output logic [31:0] rdata, output logic err);
      int idx;
`ifdef DMEM_RANGE_CHECK_EN
      err = (addr < BASE) || (addr >= BASE + 32'(4 * DEPTH)) || (addr % 4 != 0);
`else
      err = 1'b0;
`endif
      idx = int'(((addr - BASE) / 4) % DEPTH);
      rdata = 32'd0;
      if (!err) begin
         if (we) model_mem[idx] = wdata;
         else    rdata = model_mem[idx];
      end
   endfunction

   // One full transaction. Latency is the number of rising edges from the accepting edge (inclusive)
   // up to the edge after which resp_valid is visible; it must equal WAIT_CYCLES+1.
   task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata, input int hold,
                      input string name, output logic [31:0] got_rdata, output logic got_err);
      logic [31:0] exp_rdata;
      logic        exp_err;
      int          lat, n;
      model_access(we, addr, wdata, exp_rdata, exp_err);
      req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
      n = 0;
      while (req_ready !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
      vectors++;
      if (req_ready !== 1'b1) begin miscompares++; $display("FAIL %s ready_timeout req_ready=%b want 1", name, req_ready); end
      @(posedge clk); #1;
      // Scramble the inputs after acceptance; the latched request must not change.
      req_valid = 1'($urandom); req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
      lat = 1;
      while (resp_valid !== 1'b1 && lat < 40) begin @(posedge clk); #1; lat++; end
      vectors++;
      if (lat != WAITC + 1) begin miscompares++; $display("FAIL %s latency got=%0d want=%0d", name, lat, WAITC + 1); end
      vectors++;
      if (resp_rdata !== exp_rdata) begin miscompares++; $display("FAIL %s rdata got=%h want=%h", name, resp_rdata, exp_rdata); end
      vectors++;
      if (resp_err !== exp_err) begin miscompares++; $display("FAIL %s err got=%b want=%b", name, resp_err, exp_err); end
      got_rdata = resp_rdata; got_err = resp_err;
      for (int i = 0; i < hold; i++) begin
         @(posedge clk); #1;
         req_valid = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
         vectors++;
         if (resp_valid !== 1'b1 || resp_rdata !== exp_rdata || resp_err !== exp_err) begin
            miscompares++;
            $display("FAIL %s hold%0d valid=%b rdata=%h err=%b want 1/%h/%b", name, i, resp_valid, resp_rdata, resp_err, exp_rdata, exp_err);
         end
         vectors++;
         if (req_ready !== 1'b0 || busy !== 1'b1) begin
            miscompares++; $display("FAIL %s hold%0d ready=%b busy=%b want 0/1", name, i, req_ready, busy);
         end
      end
      resp_ready = 1'b1;
      @(posedge clk); #1;
      resp_ready = 1'b0; req_valid = 1'b0;
      vectors++;
      if (resp_valid !== 1'b0 || busy !== 1'b0) begin
         miscompares++; $display("FAIL %s release valid=%b busy=%b want 0/0", name, resp_valid, busy);
      end
   endtask

   task automatic test_reset();
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if ({req_ready, resp_valid, busy, resp_err} !== 4'b0000 || resp_rdata !== 32'd0) begin
         miscompares++;
         $display("FAIL reset_hold ready=%b valid=%b busy=%b err=%b rdata=%h want all 0", req_ready, resp_valid, busy, resp_err, resp_rdata);
      end
      rst = 1'b0;
      #1;
      vectors++;
      if (req_ready !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL reset_release ready=%b busy=%b want 1/0", req_ready, busy); end
      @(posedge clk); #1;
   endtask

   task automatic test_fill();
      logic [31:0] d; logic e;
      for (int i = 0; i < DEPTH; i++) txn(1'b1, BASE + 32'(4 * i), $urandom, 0, "fill", d, e);
   endtask

   task automatic test_store_load();
      logic [31:0] d; logic e;
      txn(1'b1, 32'd1028, 32'hDEADBEEF, 0, "st1028", d, e);
      txn(1'b0, 32'd1028, 32'h0, 0, "ld1028", d, e);
   endtask

   task automatic test_random();
      logic [31:0] d; logic e;
      for (int i = 0; i < 60; i++)
         txn(1'($urandom), BASE - 32'd16 + 32'($urandom_range(0, 8 * DEPTH)), $urandom, $urandom_range(0, 2), "random", d, e);
   endtask

   task automatic test_stall();
      logic [31:0] d; logic e;
      txn(1'b0, BASE + 32'(4 * $urandom_range(0, DEPTH - 1)), 32'h0, 5, "stall5", d, e);
   endtask

   task automatic test_range();
      logic [31:0] d; logic e;
`ifdef DMEM_RANGE_CHECK_EN
      txn(1'b1, 32'd1020, $urandom, 0, "st1020", d, e);
      vectors++;
      if (e !== 1'b1) begin miscompares++; $display("FAIL range_st1020 err=%b want 1", e); end
      txn(1'b0, 32'd1026, 32'h0, 0, "ld1026", d, e);
      vectors++;
      if (e !== 1'b1 || d !== 32'd0) begin miscompares++; $display("FAIL range_ld1026 err=%b rdata=%h want 1/0", e, d); end
      txn(1'b0, BASE, 32'h0, 0, "ld1024_after", d, e);
`else
      txn(1'b0, BASE + 32'(4 * DEPTH), 32'h0, 0, "ld_wrap", d, e);
      vectors++;
      if (d !== model_mem[0]) begin miscompares++; $display("FAIL wrap_index0 rdata=%h want %h", d, model_mem[0]); end
`endif
   endtask

   task automatic test_back_to_back();
      int accepts[$];
      int k, n;
      k = $urandom_range(0, DEPTH - 1);
      req_valid = 1'b1; req_we = 1'b0; req_addr = BASE + 32'(4 * k); resp_ready = 1'b1;
      for (int c = 0; c < 4 * (WAITC + 2); c++) begin
         if (req_ready === 1'b1) accepts.push_back(c);
         if (resp_valid === 1'b1) begin
            vectors++;
            if (resp_rdata !== model_mem[k]) begin miscompares++; $display("FAIL b2b rdata got=%h want=%h", resp_rdata, model_mem[k]); end
         end
         @(posedge clk); #1;
      end
      req_valid = 1'b0;
      n = 0;
      while (busy !== 1'b0 && n < 40) begin @(posedge clk); #1; n++; end
      resp_ready = 1'b0;
      vectors++;
      if (accepts.size() < 3) begin miscompares++; $display("FAIL b2b accept_count got=%0d want>=3", accepts.size()); end
      for (int i = 1; i < accepts.size(); i++) begin
         vectors++;
         if (accepts[i] - accepts[i-1] != WAITC + 2) begin
            miscompares++; $display("FAIL b2b period got=%0d want=%0d", accepts[i] - accepts[i-1], WAITC + 2);
         end
      end
   endtask

   task automatic test_reset_wait();
      logic [31:0] d; logic e;
      if (model_mem[0] == 32'h12345678) txn(1'b1, BASE, 32'h0, 0, "pre_rst", d, e);
      req_valid = 1'b1; req_we = 1'b1; req_addr = BASE; req_wdata = 32'h12345678;
      @(posedge clk); #1;
      req_valid = 1'b0;
      rst = 1'b1;
      #1;
      vectors++;
      if (busy !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b0) begin
         miscompares++; $display("FAIL rst_wait busy=%b valid=%b ready=%b want 0/0/0", busy, resp_valid, req_ready);
      end
      repeat (2) @(posedge clk);
      #1;
      vectors++;
      if (resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_wait_hold valid=%b want 0", resp_valid); end
      rst = 1'b0;
      #1;
      txn(1'b0, BASE, 32'h0, 0, "ld_after_rst", d, e);
      vectors++;
      if (d === 32'h12345678) begin miscompares++; $display("FAIL rst_wait_store_committed rdata=%h want not 12345678", d); end
   endtask

   task automatic test_zero_wait();
      logic [31:0] w;
      w = $urandom;
      for (int pass = 0; pass < 2; pass++) begin
         z_req_valid = 1'b1; z_req_we = (pass == 0); z_req_addr = BASE; z_req_wdata = w;
         vectors++;
         if (z_req_ready !== 1'b1) begin miscompares++; $display("FAIL zw%0d idle_ready=%b want 1", pass, z_req_ready); end
         @(posedge clk); #1;
         z_req_valid = 1'b0; z_req_wdata = ~w;
         vectors++;
         if (z_resp_valid !== 1'b1 || z_req_ready !== 1'b0 || z_busy !== 1'b1) begin
            miscompares++; $display("FAIL zw%0d resp valid=%b ready=%b busy=%b want 1/0/1", pass, z_resp_valid, z_req_ready, z_busy);
         end
         vectors++;
         if (z_resp_rdata !== ((pass == 0) ? 32'd0 : w) || z_resp_err !== 1'b0) begin
            miscompares++; $display("FAIL zw%0d data rdata=%h err=%b want %h/0", pass, z_resp_rdata, z_resp_err, (pass == 0) ? 32'd0 : w);
         end
         z_resp_ready = 1'b1;
         @(posedge clk); #1;
         z_resp_ready = 1'b0;
         vectors++;
         if (z_resp_valid !== 1'b0 || z_req_ready !== 1'b1) begin
            miscompares++; $display("FAIL zw%0d release valid=%b ready=%b want 0/1", pass, z_resp_valid, z_req_ready);
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog simulation did not complete");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_fill();
      test_store_load();
      test_stall();
      test_random();
      test_range();
      test_back_to_back();
      test_reset_wait();
      test_zero_wait();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/data_mem_responder.md
DATA_MEM_RESPONDER -- requirements
Module: data_mem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 64: number of 32-bit data words stored.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states between request accept and memory access, legal range 0-15.
REQ-003 Parameter BASE_ADDR, default 1024: byte address mapped to word index 0.
REQ-004 clk  input  1  sole clock; all state updates on its rising edge.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 req_valid  input  1  MEM stage presents a request.
REQ-007 req_we  input  1  1 = store word, 0 = load word.
REQ-008 req_addr  input  32  byte address.
REQ-009 req_wdata  input  32  store data.
REQ-010 req_ready  output  1  responder can accept a request this cycle.
REQ-011 resp_valid  output  1  response available.
REQ-012 resp_ready  input  1  requester consumes the response.
REQ-013 resp_rdata  output  32  load data; 0 for stores.
REQ-014 resp_err  output  1  access error flag, qualified by resp_valid.
REQ-015 busy  output  1  high whenever the FSM is not in IDLE; drives the pipeline freeze.

Function
REQ-016 FSM states: IDLE, WAIT, RESP.
REQ-017 IDLE: req_ready=1; when req_valid is high, the block latches we/addr/wdata and goes to WAIT with counter=WAIT_CYCLES-1; with WAIT_CYCLES=0 it goes straight to RESP and performs the access on the accepting edge.
REQ-018 WAIT: req_ready=0; counter decrements each cycle; at counter 0 the access executes on that edge and the FSM goes to RESP.
REQ-019 Access: index=(addr-BASE_ADDR)>>2; a store writes wdata to mem[index]; a load captures mem[index] into resp_rdata.
REQ-020 Load-to-response latency: resp_valid asserts exactly WAIT_CYCLES+1 cycles after the accepting edge.
REQ-021 RESP: resp_valid=1 and resp_rdata/resp_err stay stable until resp_ready is seen high; the FSM then returns to IDLE on that edge.
REQ-022 req_valid in WAIT or RESP is ignored, not queued; the requester holds it until req_ready.
REQ-023 Back-to-back operation: minimum accept-to-accept period is WAIT_CYCLES+2 cycles.
REQ-024 A store followed by a load to the same address returns the stored data.
REQ-025 The latched request is immune to input changes after acceptance.

Reset
REQ-026 rst asynchronously forces IDLE, counter=0, req_ready=0 while asserted then 1, resp_valid=0, resp_rdata=0, resp_err=0, busy=0.
REQ-027 Reset during WAIT discards the pending request; an uncommitted store never writes memory.
REQ-028 Memory contents are not cleared by reset.

Configuration
REQ-029 Macro DMEM_RANGE_CHECK_EN defined: an address below BASE_ADDR, at or above BASE_ADDR+4*DEPTH_WORDS, or with addr[1:0]!=0 suppresses the write, returns resp_rdata=0, and sets resp_err=1 for that response.
REQ-030 Macro DMEM_RANGE_CHECK_EN undefined: resp_err is tied to 0; the index wraps modulo DEPTH_WORDS and addr[1:0] is ignored.

Verification
REQ-031 Reset mid-WAIT: store 0x12345678 to 1024, rst pulsed in WAIT, then a load from 1024 -> the data is not 0x12345678, resp_valid=0 during reset, and busy drops immediately.
REQ-032 Store 0xDEADBEEF to 1028, then load from 1028 with WAIT_CYCLES=2 -> resp_valid 3 cycles after accept, resp_rdata=0xDEADBEEF, resp_err=0.
REQ-033 WAIT_CYCLES=0, load from 1024 -> resp_valid on the cycle after accept; req_ready low only in RESP.
REQ-034 resp_ready held low for 5 cycles in RESP -> resp_valid and resp_rdata stable for 5 cycles, and a new req_valid is not accepted.
REQ-035 DMEM_RANGE_CHECK_EN defined, store to 1020 and load from 1026 -> resp_err=1 on both, memory unchanged; undefined, load from 1024+4*64 -> returns the word at index 0.
